// File: rtl/jtag_tap_core.sv
// jtag_tap_core: IEEE 1149.1 TAP controller with IR, decoder, BYPASS/IDCODE DRs and falling-edge TDO
module jtag_tap_core #(
    parameter int                  IR_WIDTH         = 4,
    parameter logic [31:0]         IDCODE_VALUE     = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE    = 4'b0001,
    parameter logic [IR_WIDTH-1:0] BYPASS_OPCODE    = 4'b1111,
    parameter logic [IR_WIDTH-1:0] EXTEST_OPCODE    = 4'b0000,
    parameter logic [IR_WIDTH-1:0] SAMPLE_OPCODE    = 4'b0010,
    parameter int                  NUM_USER_DR      = 2,
    parameter logic [IR_WIDTH-1:0] USER_OPCODE_BASE = 4'b1000
) (
    input  logic                   TCK,
    input  logic                   TRSTN,
    input  logic                   TMS,
    input  logic                   TDI,
    output logic                   TDO,
    output logic                   TDOEnable,
    output logic                   Reset,
    output logic                   Select,
    output logic                   CaptureDR,
    output logic                   ShiftDR,
    output logic                   UpdateDR,
    output logic                   CaptureIR,
    output logic                   ShiftIR,
    output logic                   UpdateIR,
    output logic [IR_WIDTH-1:0]    Instruction,
    output logic                   Mode,
    output logic                   BsrSelect,
    input  logic                   BsrTDO,
    output logic [NUM_USER_DR-1:0] UserSelect,
    input  logic [NUM_USER_DR-1:0] UserTDO
);
    typedef enum logic [3:0] {
        stTlr, stRti,
        stSelDr, stCapDr, stShDr, stEx1Dr, stPauDr, stEx2Dr, stUpdDr,
        stSelIr, stCapIr, stShIr, stEx1Ir, stPauIr, stEx2Ir, stUpdIr
    } tapState_t;

    tapState_t state, nextState;
    logic [IR_WIDTH-1:0] irShift;
    logic [31:0] idReg;
    logic bypassReg;
    logic [NUM_USER_DR-1:0] userHit;
    logic isBypassOp, idcodeSel, bypassSel, drOut, tdoMux;

    // TAP state register, advanced by TMS on rising TCK
    always_ff @(posedge TCK or negedge TRSTN)
        if (!TRSTN) state <= stTlr;
        else state <= nextState;

    // Standard 1149.1 transition table
    always_comb begin
        nextState = state;
        case (state)
            stTlr:   nextState = TMS ? stTlr   : stRti;
            stRti:   nextState = TMS ? stSelDr : stRti;
            stSelDr: nextState = TMS ? stSelIr : stCapDr;
            stCapDr: nextState = TMS ? stEx1Dr : stShDr;
            stShDr:  nextState = TMS ? stEx1Dr : stShDr;
            stEx1Dr: nextState = TMS ? stUpdDr : stPauDr;
            stPauDr: nextState = TMS ? stEx2Dr : stPauDr;
            stEx2Dr: nextState = TMS ? stUpdDr : stShDr;
            stUpdDr: nextState = TMS ? stSelDr : stRti;
            stSelIr: nextState = TMS ? stTlr   : stCapIr;
            stCapIr: nextState = TMS ? stEx1Ir : stShIr;
            stShIr:  nextState = TMS ? stEx1Ir : stShIr;
            stEx1Ir: nextState = TMS ? stUpdIr : stPauIr;
            stPauIr: nextState = TMS ? stEx2Ir : stPauIr;
            stEx2Ir: nextState = TMS ? stUpdIr : stShIr;
            stUpdIr: nextState = TMS ? stSelDr : stRti;
            default: nextState = stTlr;
        endcase
    end

    assign Reset     = state == stTlr;
    assign Select    = state >= stSelIr;
    assign CaptureDR = state == stCapDr;
    assign ShiftDR   = state == stShDr;
    assign UpdateDR  = state == stUpdDr;
    assign CaptureIR = state == stCapIr;
    assign ShiftIR   = state == stShIr;
    assign UpdateIR  = state == stUpdIr;

    for (genvar k = 0; k < NUM_USER_DR; k++) begin : gUser
        assign userHit[k] = Instruction == USER_OPCODE_BASE + IR_WIDTH'(k);
    end

    assign isBypassOp = Instruction == BYPASS_OPCODE;
    assign idcodeSel  = !isBypassOp && Instruction == IDCODE_OPCODE;
    assign BsrSelect  = !isBypassOp && !idcodeSel && (Instruction == EXTEST_OPCODE || Instruction == SAMPLE_OPCODE);
    assign UserSelect = (isBypassOp || idcodeSel || BsrSelect) ? '0 : userHit;
    assign bypassSel  = !(idcodeSel || BsrSelect || |UserSelect);
    assign Mode       = Instruction == EXTEST_OPCODE;

    assign drOut  = idcodeSel ? idReg[0] : BsrSelect ? BsrTDO : |UserSelect ? |(UserSelect & UserTDO) : bypassReg;
    assign tdoMux = ShiftIR ? irShift[0] : drOut;

    // Instruction shift register: capture 01 pattern, shift LSB out
    always_ff @(posedge TCK or negedge TRSTN)
        if (!TRSTN) irShift <= '0;
        else if (CaptureIR) irShift <= IR_WIDTH'(2'b01);
        else if (ShiftIR) irShift <= {TDI, irShift[IR_WIDTH-1:1]};

    // Single-bit bypass register
    always_ff @(posedge TCK or negedge TRSTN)
        if (!TRSTN) bypassReg <= 1'b0;
        else if (bypassSel && CaptureDR) bypassReg <= 1'b0;
        else if (bypassSel && ShiftDR) bypassReg <= TDI;

    // IDCODE register, reloaded on capture
    always_ff @(posedge TCK or negedge TRSTN)
        if (!TRSTN) idReg <= IDCODE_VALUE;
        else if (idcodeSel && CaptureDR) idReg <= IDCODE_VALUE;
        else if (idcodeSel && ShiftDR) idReg <= {TDI, idReg[31:1]};

    // Falling-edge instruction latch and retimed TDO/TDOEnable
    always_ff @(negedge TCK or negedge TRSTN)
        if (!TRSTN) begin
            Instruction <= IDCODE_OPCODE;
            TDO         <= 1'b0;
            TDOEnable   <= 1'b0;
        end else begin
            if (Reset) Instruction <= IDCODE_OPCODE;
            else if (UpdateIR) Instruction <= irShift;
            TDOEnable <= ShiftDR || ShiftIR;
            TDO       <= (ShiftDR || ShiftIR) && tdoMux;
        end
endmodule
